// File: rtl/l2_cache_ctrl_burst.sv
// Control FSM for the N-way unified L2 cache: lookup, multi-beat writeback/refill bursts,
// write-around on write miss (optional), and saturating hit/miss/writeback counters.
module l2_cache_ctrl_burst #(
    parameter int NUM_WAYS      = 4,
    parameter int BURST_LEN     = 4,
    parameter int LOOKUP_CYCLES = 1,
    parameter int WRITE_ALLOC   = 1,
    parameter int CNT_W         = 16,
    parameter int WAY_W         = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
    parameter int BEAT_W        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    output logic              mem_resp,
    input  logic              is_hit,
    input  logic [WAY_W-1:0]  hit_way,
    input  logic              is_dirty,
    input  logic [WAY_W-1:0]  victim_way,
    output logic              pmem_read,
    output logic              pmem_write,
    input  logic              pmem_resp,
    output logic [BEAT_W-1:0] beat_idx,
    output logic              pmem_addr_sel,
    output logic [WAY_W-1:0]  way_sel,
    output logic              load_data,
    output logic              load_tag,
    output logic              load_valid,
    output logic              load_dirty,
    output logic              load_plru,
    output logic              valid_in,
    output logic              dirty_in,
    output logic              is_allocate,
    output logic              busy,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt,
    output logic [CNT_W-1:0]  wb_cnt
);
    localparam int LK_W = (LOOKUP_CYCLES > 1) ? $clog2(LOOKUP_CYCLES) : 1;
    localparam logic [LK_W-1:0]   LK_LAST   = LK_W'(LOOKUP_CYCLES - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        LOOKUP       = 3'd1,
        WRITE_BACK   = 3'd2,
        ALLOCATE     = 3'd3,
        WRITE_AROUND = 3'd4
    } state_t;

    state_t            state_r;
    logic [LK_W-1:0]   lk_cnt_r;
    logic [BEAT_W-1:0] beat_cnt_r;
    logic [WAY_W-1:0]  victim_q_r;
    logic              relook_r;
    logic [CNT_W-1:0]  hit_cnt_r;
    logic [CNT_W-1:0]  miss_cnt_r;
    logic [CNT_W-1:0]  wb_cnt_r;
    logic              lk_done_s;
    logic              last_beat_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        sat_inc = (c == CNT_MAX) ? c : c + CNT_W'(1);
    endfunction

    assign lk_done_s   = (state_r == LOOKUP) && (lk_cnt_r == LK_LAST);
    assign last_beat_s = (beat_cnt_r == BEAT_LAST);
    assign hit_cnt     = hit_cnt_r;
    assign miss_cnt    = miss_cnt_r;
    assign wb_cnt      = wb_cnt_r;

    // State, lookup/beat counters, frozen victim and performance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            lk_cnt_r   <= '0;
            beat_cnt_r <= '0;
            victim_q_r <= '0;
            relook_r   <= 1'b0;
            hit_cnt_r  <= '0;
            miss_cnt_r <= '0;
            wb_cnt_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (mem_read ^ mem_write) begin
                        state_r  <= LOOKUP;
                        lk_cnt_r <= '0;
                        relook_r <= 1'b0;
                    end
                end
                LOOKUP: begin
                    lk_cnt_r <= lk_cnt_r + LK_W'(1);
                    if (lk_done_s) begin
                        lk_cnt_r <= '0;
                        // The re-lookup after a refill must not be counted twice
                        if (is_hit) begin
                            state_r  <= IDLE;
                            relook_r <= 1'b0;
                            if (!relook_r) hit_cnt_r <= sat_inc(hit_cnt_r);
                        end else if (mem_write && (WRITE_ALLOC == 0)) begin
                            state_r <= WRITE_AROUND;
                            if (!relook_r) miss_cnt_r <= sat_inc(miss_cnt_r);
                        end else begin
                            victim_q_r <= victim_way;
                            beat_cnt_r <= '0;
                            state_r    <= is_dirty ? WRITE_BACK : ALLOCATE;
                            if (!relook_r) miss_cnt_r <= sat_inc(miss_cnt_r);
                        end
                    end
                end
                WRITE_BACK: begin
                    if (pmem_resp) begin
                        if (last_beat_s) begin
                            beat_cnt_r <= '0;
                            wb_cnt_r   <= sat_inc(wb_cnt_r);
                            state_r    <= ALLOCATE;
                        end else begin
                            beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
                        end
                    end
                end
                ALLOCATE: begin
                    if (pmem_resp) begin
                        if (last_beat_s) begin
                            beat_cnt_r <= '0;
                            lk_cnt_r   <= '0;
                            relook_r   <= 1'b1;
                            state_r    <= LOOKUP;
                        end else begin
                            beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
                        end
                    end
                end
                WRITE_AROUND: begin
                    if (pmem_resp) state_r <= IDLE;
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // Output decode from current state and datapath/pmem inputs
    always_comb begin
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        beat_idx      = '0;
        pmem_addr_sel = 1'b0;
        way_sel       = '0;
        load_data     = 1'b0;
        load_tag      = 1'b0;
        load_valid    = 1'b0;
        load_dirty    = 1'b0;
        load_plru     = 1'b0;
        valid_in      = 1'b0;
        dirty_in      = 1'b0;
        is_allocate   = 1'b0;
        busy          = (state_r != IDLE);
        case (state_r)
            IDLE: begin
                busy = 1'b0;
            end
            LOOKUP: begin
                if (lk_done_s && is_hit) begin
                    mem_resp  = 1'b1;
                    load_plru = 1'b1;
                    way_sel   = hit_way;
                    if (mem_write) begin
                        load_data  = 1'b1;
                        load_dirty = 1'b1;
                        dirty_in   = 1'b1;
                    end else begin
                        load_data  = 1'b0;
                    end
                end else begin
                    mem_resp = 1'b0;
                end
            end
            WRITE_BACK: begin
                pmem_write    = 1'b1;
                pmem_addr_sel = 1'b1;
                way_sel       = victim_q_r;
                beat_idx      = beat_cnt_r;
            end
            ALLOCATE: begin
                pmem_read   = 1'b1;
                is_allocate = 1'b1;
                way_sel     = victim_q_r;
                beat_idx    = beat_cnt_r;
                load_data   = pmem_resp;
                // Tag/valid/dirty commit together with the final data beat
                if (pmem_resp && last_beat_s) begin
                    load_tag   = 1'b1;
                    load_valid = 1'b1;
                    load_dirty = 1'b1;
                    valid_in   = 1'b1;
                end else begin
                    load_tag   = 1'b0;
                end
            end
            WRITE_AROUND: begin
                pmem_write = 1'b1;
                mem_resp   = pmem_resp;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_l2_cache_ctrl_burst.sv
// Scoreboard bench for l2_cache_ctrl_burst: instance A (write-allocate, 4-beat, 2-cycle lookup,
// 2-bit counters) and instance B (write-around, 1-beat, 1-cycle lookup), selected by sel_b.
`timescale 1ns/1ps
module tb_l2_cache_ctrl_burst;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, sel_b, mem_read, mem_write, is_hit, is_dirty, pmem_resp;
    logic [1:0] hit_way, victim_way;

    logic a_mem_resp, a_pmem_read, a_pmem_write, a_pmem_addr_sel, a_load_data, a_load_tag;
    logic a_load_valid, a_load_dirty, a_load_plru, a_valid_in, a_dirty_in, a_is_allocate, a_busy;
    logic [1:0] a_beat_idx, a_way_sel, a_hit_cnt, a_miss_cnt, a_wb_cnt;
    logic b_mem_resp, b_pmem_read, b_pmem_write, b_pmem_addr_sel, b_load_data, b_load_tag;
    logic b_load_valid, b_load_dirty, b_load_plru, b_valid_in, b_dirty_in, b_is_allocate, b_busy;
    logic [0:0]  b_beat_idx;
    logic [1:0]  b_way_sel;
    logic [15:0] b_hit_cnt, b_miss_cnt, b_wb_cnt;

    logic mem_resp, pmem_read, pmem_write, pmem_addr_sel, load_data, load_tag;
    logic load_valid, load_dirty, load_plru, valid_in, dirty_in, is_allocate, busy;
    logic [1:0]  beat_idx, way_sel;
    logic [15:0] hit_cnt, miss_cnt, wb_cnt;

    assign mem_resp      = sel_b ? b_mem_resp      : a_mem_resp;
    assign pmem_read     = sel_b ? b_pmem_read     : a_pmem_read;
    assign pmem_write    = sel_b ? b_pmem_write    : a_pmem_write;
    assign pmem_addr_sel = sel_b ? b_pmem_addr_sel : a_pmem_addr_sel;
    assign load_data     = sel_b ? b_load_data     : a_load_data;
    assign load_tag      = sel_b ? b_load_tag      : a_load_tag;
    assign load_valid    = sel_b ? b_load_valid    : a_load_valid;
    assign load_dirty    = sel_b ? b_load_dirty    : a_load_dirty;
    assign load_plru     = sel_b ? b_load_plru     : a_load_plru;
    assign valid_in      = sel_b ? b_valid_in      : a_valid_in;
    assign dirty_in      = sel_b ? b_dirty_in      : a_dirty_in;
    assign is_allocate   = sel_b ? b_is_allocate   : a_is_allocate;
    assign busy          = sel_b ? b_busy          : a_busy;
    assign beat_idx      = sel_b ? {1'b0, b_beat_idx} : a_beat_idx;
    assign way_sel       = sel_b ? b_way_sel       : a_way_sel;
    assign hit_cnt       = sel_b ? b_hit_cnt       : {14'd0, a_hit_cnt};
    assign miss_cnt      = sel_b ? b_miss_cnt      : {14'd0, a_miss_cnt};
    assign wb_cnt        = sel_b ? b_wb_cnt        : {14'd0, a_wb_cnt};

    l2_cache_ctrl_burst #(.NUM_WAYS(4), .BURST_LEN(4), .LOOKUP_CYCLES(2), .WRITE_ALLOC(1), .CNT_W(2)) dut_a (
        .clk(clk), .rst(rst), .mem_read(mem_read & ~sel_b), .mem_write(mem_write & ~sel_b),
        .mem_resp(a_mem_resp), .is_hit(is_hit), .hit_way(hit_way), .is_dirty(is_dirty),
        .victim_way(victim_way), .pmem_read(a_pmem_read), .pmem_write(a_pmem_write),
        .pmem_resp(pmem_resp & ~sel_b), .beat_idx(a_beat_idx), .pmem_addr_sel(a_pmem_addr_sel),
        .way_sel(a_way_sel), .load_data(a_load_data), .load_tag(a_load_tag), .load_valid(a_load_valid),
        .load_dirty(a_load_dirty), .load_plru(a_load_plru), .valid_in(a_valid_in), .dirty_in(a_dirty_in),
        .is_allocate(a_is_allocate), .busy(a_busy), .hit_cnt(a_hit_cnt), .miss_cnt(a_miss_cnt),
        .wb_cnt(a_wb_cnt));

    l2_cache_ctrl_burst #(.NUM_WAYS(4), .BURST_LEN(1), .LOOKUP_CYCLES(1), .WRITE_ALLOC(0), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .mem_read(mem_read & sel_b), .mem_write(mem_write & sel_b),
        .mem_resp(b_mem_resp), .is_hit(is_hit), .hit_way(hit_way), .is_dirty(is_dirty),
        .victim_way(victim_way), .pmem_read(b_pmem_read), .pmem_write(b_pmem_write),
        .pmem_resp(pmem_resp & sel_b), .beat_idx(b_beat_idx), .pmem_addr_sel(b_pmem_addr_sel),
        .way_sel(b_way_sel), .load_data(b_load_data), .load_tag(b_load_tag), .load_valid(b_load_valid),
        .load_dirty(b_load_dirty), .load_plru(b_load_plru), .valid_in(b_valid_in), .dirty_in(b_dirty_in),
        .is_allocate(b_is_allocate), .busy(b_busy), .hit_cnt(b_hit_cnt), .miss_cnt(b_miss_cnt),
        .wb_cnt(b_wb_cnt));

    typedef struct packed {
        logic [1:0] beat;
        logic [1:0] way;
        logic       wr;
        logic       sel;
        logic       alloc;
        logic       last;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    exp_hit[2], exp_miss[2], exp_wb[2];

    function automatic int sat(input int v, input logic b);
        int cmax;
        cmax = b ? 65535 : 3;
        sat = (v > cmax) ? cmax : v;
    endfunction

    task automatic push_burst(input logic wr, input logic sel, input logic alloc, input logic [1:0] way,
                              input int n);
        beat_t e;
        for (int i = 0; i < n; i++) begin
            e.beat = 2'(i); e.way = way; e.wr = wr; e.sel = sel; e.alloc = alloc; e.last = (i == n - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic release_req();
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
        #1;
    endtask

    // pmem responder and beat scoreboard; returns once mem_resp is seen or max_beats served
    task automatic serve(input int stall_beat, input int stall_len, input int max_beats, output bit done);
        int beats, stalled;
        bit stop;
        beat_t e;
        logic [1:0]  expb;
        logic [12:0] got, want;
        beats = 0; stalled = 0; done = 1'b0; stop = 1'b0;
        for (int c = 0; c < 200 && !done && !stop; c++) begin
            @(negedge clk);
            pmem_resp = 1'b0;
            #1;
            checks++;
            if (pmem_read && pmem_write) begin
                errors++;
                $display("FAIL pmem_exclusive: pmem_read=%b pmem_write=%b, required not both high", pmem_read, pmem_write);
            end
            if (mem_resp) begin
                done = 1'b1;
            end else if (pmem_read || pmem_write) begin
                if (beats == stall_beat && stalled < stall_len) begin
                    stalled++;
                    expb = (exp_q.size() > 0) ? exp_q[0].beat : 2'd0;
                    checks++;
                    if ({beat_idx, load_data} !== {expb, 1'b0}) begin
                        errors++;
                        $display("FAIL wait_state: beat_idx=%0d load_data=%b, required beat_idx=%0d load_data=0", beat_idx, load_data, expb);
                    end
                end else begin
                    pmem_resp = 1'b1;
                    #1;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat: beat_idx=%0d, required no beat", beat_idx);
                    end else begin
                        e = exp_q.pop_front();
                        got  = {beat_idx, way_sel, pmem_write, pmem_read, pmem_addr_sel, load_data,
                                is_allocate, load_tag, load_valid, load_dirty, valid_in, dirty_in};
                        want = {e.beat, e.way, e.wr, ~e.wr, e.sel, e.alloc, e.alloc, e.alloc & e.last,
                                e.alloc & e.last, e.alloc & e.last, e.alloc & e.last, 1'b0};
                        if (got !== want) begin
                            errors++;
                            $display("FAIL beat: got %b, required %b (beat,way,wr,rd,sel,ld,alloc,tag,val,dty,vin,din)", got, want);
                        end
                        if (e.alloc && e.last) is_hit = 1'b1;
                    end
                    victim_way = victim_way ^ 2'b01;
                    beats++;
                    if (mem_resp) done = 1'b1;
                    else if (max_beats > 0 && beats == max_beats) stop = 1'b1;
                end
            end
        end
        if (!done && !stop) begin
            checks++; errors++;
            $display("FAIL serve_timeout: no mem_resp within 200 cycles, %0d beats left expected", exp_q.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        checks++;
        if ({mem_resp, pmem_read, pmem_write, beat_idx, way_sel, load_data, load_plru, busy, hit_cnt, miss_cnt, wb_cnt} !== 57'd0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b pmem_read=%b hit=%0d miss=%0d wb=%0d, required all 0", busy, pmem_read, hit_cnt, miss_cnt, wb_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_read_hit();
        sel_b = 1'b0; is_hit = 1'b1; hit_way = 2'd1;
        @(negedge clk); mem_read = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({busy, mem_resp} !== 2'b10) begin
            errors++; $display("FAIL hit_latency_t1: busy=%b mem_resp=%b, required busy=1 mem_resp=0", busy, mem_resp);
        end
        @(negedge clk); #1;
        checks++;
        if ({mem_resp, load_plru, way_sel, load_data, load_dirty} !== {1'b1, 1'b1, 2'd1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL read_hit_t2: resp=%b plru=%b way=%0d ld=%b, required 1 1 1 0", mem_resp, load_plru, way_sel, load_data);
        end
        exp_hit[0]++;
        release_req();
        checks++;
        if ({busy, hit_cnt, miss_cnt} !== {1'b0, 16'(sat(exp_hit[0], 1'b0)), 16'(sat(exp_miss[0], 1'b0))}) begin
            errors++; $display("FAIL read_hit_cnt: busy=%b hit=%0d miss=%0d, required 0 %0d %0d", busy, hit_cnt, miss_cnt, exp_hit[0], exp_miss[0]);
        end
    endtask

    task automatic test_clean_read_miss();
        bit done;
        sel_b = 1'b0; is_hit = 1'b0; is_dirty = 1'b0; victim_way = 2'd2; hit_way = 2'd2;
        push_burst(1'b0, 1'b0, 1'b1, 2'd2, 4);
        exp_miss[0]++;
        @(negedge clk); mem_read = 1'b1;
        serve(-1, 0, 0, done);
        checks++;
        if ({mem_resp, load_plru, way_sel, load_data, exp_q.size() == 0} !== {1'b1, 1'b1, 2'd2, 1'b0, 1'b1}) begin
            errors++; $display("FAIL miss_relookup: resp=%b plru=%b way=%0d ld=%b left=%0d, required 1 1 2 0 0", mem_resp, load_plru, way_sel, load_data, exp_q.size());
        end
        release_req();
        checks++;
        if ({hit_cnt, miss_cnt, wb_cnt} !== {16'(sat(exp_hit[0], 1'b0)), 16'(sat(exp_miss[0], 1'b0)), 16'(sat(exp_wb[0], 1'b0))}) begin
            errors++; $display("FAIL miss_cnt: hit=%0d miss=%0d wb=%0d, required %0d %0d %0d", hit_cnt, miss_cnt, wb_cnt, exp_hit[0], exp_miss[0], exp_wb[0]);
        end
    endtask

    task automatic test_dirty_write_miss();
        bit done;
        sel_b = 1'b0; is_hit = 1'b0; is_dirty = 1'b1; victim_way = 2'd1; hit_way = 2'd1;
        push_burst(1'b1, 1'b1, 1'b0, 2'd1, 4);
        push_burst(1'b0, 1'b0, 1'b1, 2'd1, 4);
        exp_miss[0]++; exp_wb[0]++;
        @(negedge clk); mem_write = 1'b1;
        serve(2, 3, 0, done);
        checks++;
        if ({mem_resp, load_plru, way_sel, load_data, load_dirty, dirty_in} !== {1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1}) begin
            errors++; $display("FAIL write_hit_after_fill: resp=%b plru=%b way=%0d ld=%b ldd=%b din=%b, required 1 1 1 1 1 1", mem_resp, load_plru, way_sel, load_data, load_dirty, dirty_in);
        end
        release_req();
        is_dirty = 1'b0;
        checks++;
        if ({hit_cnt, miss_cnt, wb_cnt} !== {16'(sat(exp_hit[0], 1'b0)), 16'(sat(exp_miss[0], 1'b0)), 16'(sat(exp_wb[0], 1'b0))}) begin
            errors++; $display("FAIL dirty_cnt: hit=%0d miss=%0d wb=%0d, required %0d %0d %0d", hit_cnt, miss_cnt, wb_cnt, exp_hit[0], exp_miss[0], exp_wb[0]);
        end
    endtask

    task automatic test_reset_mid_alloc();
        bit done;
        sel_b = 1'b0; is_hit = 1'b0; is_dirty = 1'b0; victim_way = 2'd3; hit_way = 2'd3;
        push_burst(1'b0, 1'b0, 1'b1, 2'd3, 4);
        @(negedge clk); mem_read = 1'b1;
        serve(-1, 0, 2, done);
        @(negedge clk); pmem_resp = 1'b0; #1;
        checks++;
        if ({busy, pmem_read, beat_idx} !== {1'b1, 1'b1, 2'd2}) begin
            errors++; $display("FAIL pre_reset: busy=%b pmem_read=%b beat=%0d, required 1 1 2", busy, pmem_read, beat_idx);
        end
        rst = 1'b1; mem_read = 1'b0; #1;
        checks++;
        if ({mem_resp, pmem_read, pmem_write, beat_idx, pmem_addr_sel, way_sel, load_data, load_tag, load_valid,
             load_dirty, load_plru, valid_in, dirty_in, is_allocate, busy, hit_cnt, miss_cnt, wb_cnt} !== 65'd0) begin
            errors++; $display("FAIL reset_mid_burst: pmem_read=%b beat=%0d busy=%b miss=%0d, required all 0", pmem_read, beat_idx, busy, miss_cnt);
        end
        exp_q.delete();
        exp_hit = '{0, 0}; exp_miss = '{0, 0}; exp_wb = '{0, 0};
        @(negedge clk); rst = 1'b0;
        victim_way = 2'd0; hit_way = 2'd0;
        push_burst(1'b0, 1'b0, 1'b1, 2'd0, 4);
        exp_miss[0]++;
        @(negedge clk); mem_read = 1'b1;
        serve(-1, 0, 0, done);
        checks++;
        if ({mem_resp, exp_q.size() == 0} !== 2'b11) begin
            errors++; $display("FAIL restart_after_reset: resp=%b left=%0d, required 1 0", mem_resp, exp_q.size());
        end
        release_req();
        mem_read = 1'b1; mem_write = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++;
            if (busy !== 1'b0) begin
                errors++; $display("FAIL both_req_idle: busy=%b, required 0", busy);
            end
        end
        mem_read = 1'b0; mem_write = 1'b0;
        checks++;
        if ({hit_cnt, miss_cnt, wb_cnt} !== {16'(sat(exp_hit[0], 1'b0)), 16'(sat(exp_miss[0], 1'b0)), 16'(sat(exp_wb[0], 1'b0))}) begin
            errors++; $display("FAIL post_reset_cnt: hit=%0d miss=%0d wb=%0d, required %0d %0d %0d", hit_cnt, miss_cnt, wb_cnt, exp_hit[0], exp_miss[0], exp_wb[0]);
        end
    endtask

    task automatic test_saturation();
        bit done;
        sel_b = 1'b0; is_hit = 1'b1; hit_way = 2'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); mem_read = 1'b1;
            serve(-1, 0, 0, done);
            exp_hit[0]++;
            release_req();
            checks++;
            if (hit_cnt !== 16'(sat(exp_hit[0], 1'b0))) begin
                errors++; $display("FAIL hit_saturate: hit_cnt=%0d, required %0d", hit_cnt, sat(exp_hit[0], 1'b0));
            end
        end
    endtask

    task automatic test_write_around();
        bit done;
        sel_b = 1'b1; is_hit = 1'b0; is_dirty = 1'b0; victim_way = 2'd2;
        push_burst(1'b1, 1'b0, 1'b0, 2'd0, 1);
        exp_miss[1]++;
        @(negedge clk); mem_write = 1'b1;
        serve(-1, 0, 0, done);
        checks++;
        if ({mem_resp, load_data, load_tag, load_valid, load_dirty, load_plru, is_allocate} !== 7'b1000000) begin
            errors++; $display("FAIL write_around_resp: resp=%b loads=%b%b%b%b%b alloc=%b, required 1 00000 0", mem_resp, load_data, load_tag, load_valid, load_dirty, load_plru, is_allocate);
        end
        release_req();
        checks++;
        if ({hit_cnt, miss_cnt, wb_cnt} !== {16'(sat(exp_hit[1], 1'b1)), 16'(sat(exp_miss[1], 1'b1)), 16'(sat(exp_wb[1], 1'b1))}) begin
            errors++; $display("FAIL write_around_cnt: hit=%0d miss=%0d wb=%0d, required %0d %0d %0d", hit_cnt, miss_cnt, wb_cnt, exp_hit[1], exp_miss[1], exp_wb[1]);
        end
    endtask

    task automatic test_burst_len1();
        bit done;
        sel_b = 1'b1; is_hit = 1'b0; is_dirty = 1'b1; victim_way = 2'd2; hit_way = 2'd2;
        push_burst(1'b1, 1'b1, 1'b0, 2'd2, 1);
        push_burst(1'b0, 1'b0, 1'b1, 2'd2, 1);
        exp_miss[1]++; exp_wb[1]++;
        @(negedge clk); mem_read = 1'b1;
        serve(-1, 0, 0, done);
        checks++;
        if ({mem_resp, load_plru, way_sel, exp_q.size() == 0} !== {1'b1, 1'b1, 2'd2, 1'b1}) begin
            errors++; $display("FAIL burst1_resp: resp=%b plru=%b way=%0d left=%0d, required 1 1 2 0", mem_resp, load_plru, way_sel, exp_q.size());
        end
        release_req();
        is_dirty = 1'b0;
        checks++;
        if ({hit_cnt, miss_cnt, wb_cnt} !== {16'(sat(exp_hit[1], 1'b1)), 16'(sat(exp_miss[1], 1'b1)), 16'(sat(exp_wb[1], 1'b1))}) begin
            errors++; $display("FAIL burst1_cnt: hit=%0d miss=%0d wb=%0d, required %0d %0d %0d", hit_cnt, miss_cnt, wb_cnt, exp_hit[1], exp_miss[1], exp_wb[1]);
        end
    endtask

    initial begin
        rst = 1'b1; sel_b = 1'b0; mem_read = 1'b0; mem_write = 1'b0; is_hit = 1'b0; is_dirty = 1'b0;
        pmem_resp = 1'b0; hit_way = 2'd0; victim_way = 2'd0;
        exp_hit = '{0, 0}; exp_miss = '{0, 0}; exp_wb = '{0, 0};
        test_reset();
        test_read_hit();
        test_clean_read_miss();
        test_dirty_write_miss();
        test_reset_mid_alloc();
        test_saturation();
        test_write_around();
        test_burst_len1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within 500000 ns");
        $fatal(1);
    end
endmodule
